rv32_seq_ctrl: RTL and testbench
================================

Name: rv32_seq_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It steps one instruction at a time through fetch, decode, execute, memory and write-back, and drives the instruction-memory and data-memory request handshakes. It gates the register-file write enables produced by the instruction decoder and owns the PC, the IR and the retired-instruction count. It sits between the memories and the combinational decoder/ALU datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 255, maximum wait cycles for imem_ready/dmem_ready before trap (1..65535)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address (= pc)
imem_ready  input  1  fetch data valid this cycle
imem_rdata  input  32  fetched instruction
ir  output  32  latched instruction, drives decoder instr
pc  output  32  current PC, drives decoder PC
dec_branch  input  1  decoder Branch
dec_memread  input  1  decoder MemRead
dec_we  input  4  decoder store byte enables
dec_regwrite  input  4  decoder register byte-write enables
branch_taken  input  1  ALU compare result for current branch
imm  input  32  decoder immediate
alu_result  input  32  ALU output (JALR target, load/store address)
dmem_req  output  1  data memory request
dmem_we  output  4  data memory byte write enables
dmem_ready  input  1  data access complete
rf_we  output  4  gated register-file byte write enables
instret  output  32  retired instruction counter
halted  output  1  sticky trap indicator
trap_cause  output  2  00 none, 01 illegal, 10 misaligned target, 11 memory timeout

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, ir=32'h0000_0013 (NOP), instret=0, halted=0, trap_cause=00, imem_req=dmem_req=0, dmem_we=0, rf_we=0, timeout counter=0. Reset dominates every state, including mid-handshake; requests drop at that edge.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready: ir<=imem_rdata, go to DECODE. Data is accepted the same cycle ready is seen.
- DECODE: one cycle for decoder settling.
  - Illegal if ir[1:0]!=2'b11 or ir[6:2] is not one of {01101,00101,11011,11001,11000,00000,01000,00100,01100}; illegal goes to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - If dec_memread=1 or dec_we!=0, go to MEM.
  - Else if dec_regwrite!=0, go to WB.
  - Else (branch) do the PC update, go to FETCH.
- MEM: dmem_req=1, dmem_we=dec_we for the whole wait (0 for loads). Inputs hold stable while waiting. On dmem_ready: a load goes to WB; a store does the PC update and goes to FETCH.
- WB: rf_we=dec_regwrite for exactly one cycle, forced to 0 if ir[11:7]==0. Then PC update, go to FETCH.
- PC update (on leaving EXEC/MEM/WB toward FETCH):
  - JAL: next_pc = pc+imm.
  - JALR: next_pc = alu_result & ~32'h1.
  - Branch with branch_taken=1: next_pc = pc+imm.
  - Otherwise: next_pc = pc+4.
  - Arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
  - If next_pc[1:0]!=0: pc is not updated, instret is not incremented, go to TRAP with cause 10.
  - Otherwise pc<=next_pc and instret<=instret+1, wrapping at 2^32.
- Timeout: the counter clears on entry to FETCH/MEM and increments each waiting cycle. A ready seen in the same cycle the counter reaches MEM_TIMEOUT counts as success. Reaching MEM_TIMEOUT without ready goes to TRAP with cause 11.
- TRAP: halted=1, all requests and rf_we are 0, pc/ir frozen, stays until rst.
- rf_we and dmem_we are 0 in every state other than WB and MEM respectively.

Optional Feature:
SEQ_SINGLE_STEP_EN:
- When defined, ports step_mode (in, 1) and step (in, 1) are added. With step_mode=1, IDLE and every transition into FETCH wait in a HOLD state until step=1 for one cycle, then enter FETCH. One instruction runs per pulse. A step held high for several cycles counts as one pulse (rising-edge detect). step_mode=0 behaves as base.
- When undefined, the ports and HOLD state are absent, and FETCH follows directly.

Test Plan:
1. Reset with RESET_PC=32'h100, imem returns ADDI x1,x0,5 (32'h00500093) with ready after 2 cycles -> FETCH holds imem_req 3 cycles; rf_we=4'b1111 for one cycle in WB; pc=32'h104; instret=1.
2. SW x2,8(x1) (32'h0020A423), dec_we=4'b1111, dmem_ready after 3 cycles -> dmem_we=4'b1111 stable for 4 cycles, rf_we never asserted, pc+=4.
3. BEQ with imm=32'hFFFF_FFF8 at pc=32'h200: branch_taken=1 -> pc=32'h1F8; branch_taken=0 -> pc=32'h204.
4. JALR with alu_result=32'h0000_0302 -> trap, cause 10, halted=1, pc unchanged, instret unchanged.
5. Instruction 32'h0000_0000 -> TRAP cause 01. Separately, imem_ready never asserted with MEM_TIMEOUT=4 -> TRAP cause 11 after 4 wait cycles.
6. Assert rst during MEM wait -> dmem_req=0 next cycle, pc=RESET_PC, instret=0, state IDLE. ADDI to x0 -> rf_we stays 0.

Source files
------------

// File: rtl/rv32_seq_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/memory/write-back stepping,
// memory handshakes, PC/IR/instret ownership. Optional single-step via SEQ_SINGLE_STEP_EN.
module rv32_seq_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic [31:0] pc,
   input  logic        dec_branch,
   input  logic        dec_memread,
   input  logic [3:0]  dec_we,
   input  logic [3:0]  dec_regwrite,
   input  logic        branch_taken,
   input  logic [31:0] imm,
   input  logic [31:0] alu_result,
   output logic        dmem_req,
   output logic [3:0]  dmem_we,
   input  logic        dmem_ready,
   output logic [3:0]  rf_we,
   output logic [31:0] instret,
   output logic        halted,
   output logic [1:0]  trap_cause
`ifdef SEQ_SINGLE_STEP_EN
   ,
   input  logic        step_mode,
   input  logic        step
`endif
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd6;
`ifdef SEQ_SINGLE_STEP_EN
   localparam logic [2:0] S_HOLD   = 3'd7;
`endif

   localparam logic [4:0] OPC_JAL  = 5'b11011;
   localparam logic [4:0] OPC_JALR = 5'b11001;

   logic [2:0]       state, state_nxt, fetch_tgt;
   logic [31:0]      pc_nxt, ir_nxt, instret_nxt, target;
   logic [1:0]       cause_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             opc_ok, illegal, do_upd;

   assign imem_addr = pc;

`ifdef SEQ_SINGLE_STEP_EN
   logic step_q, step_pulse;
   assign step_pulse = step & ~step_q;
   assign fetch_tgt  = step_mode ? S_HOLD : S_FETCH;

   // Level-held step counts once: only its rising edge releases HOLD.
   always_ff @(posedge clk) begin
      if (rst) step_q <= 1'b0;
      else     step_q <= step;
   end
`else
   assign fetch_tgt = S_FETCH;
`endif

   always_comb begin
      case (ir[6:2])
         5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
         5'b00000, 5'b01000, 5'b00100, 5'b01100: opc_ok = 1'b1;
         default:                                opc_ok = 1'b0;
      endcase
   end
   assign illegal = (ir[1:0] != 2'b11) || !opc_ok;

   // Next PC candidate for the instruction currently in IR.
   always_comb begin
      if (ir[6:2] == OPC_JAL)              target = pc + imm;
      else if (ir[6:2] == OPC_JALR)        target = alu_result & ~32'h1;
      else if (dec_branch && branch_taken) target = pc + imm;
      else                                 target = pc + 32'd4;
   end

   // Next-state and next-value logic.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      ir_nxt      = ir;
      instret_nxt = instret;
      cause_nxt   = trap_cause;
      cnt_nxt     = cnt;
      do_upd      = 1'b0;
      case (state)
         S_IDLE: state_nxt = fetch_tgt;
`ifdef SEQ_SINGLE_STEP_EN
         S_HOLD: if (!step_mode || step_pulse) state_nxt = S_FETCH;
`endif
         S_FETCH: begin
            if (imem_ready) begin
               ir_nxt    = imem_rdata;
               state_nxt = S_DECODE;
            end else if (cnt == TO_LAST) begin
               state_nxt = S_TRAP;
               cause_nxt = 2'b11;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         S_DECODE: begin
            if (illegal) begin
               state_nxt = S_TRAP;
               cause_nxt = 2'b01;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (dec_memread || (dec_we != 4'b0000)) state_nxt = S_MEM;
            else if (dec_regwrite != 4'b0000)      state_nxt = S_WB;
            else                                    do_upd    = 1'b1;
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (dec_memread) state_nxt = S_WB;
               else             do_upd    = 1'b1;
            end else if (cnt == TO_LAST) begin
               state_nxt = S_TRAP;
               cause_nxt = 2'b11;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         S_WB:    do_upd    = 1'b1;
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_IDLE;
      endcase

      // A misaligned target retires nothing and leaves PC on the faulting instruction.
      if (do_upd) begin
         if (target[1:0] != 2'b00) begin
            state_nxt = S_TRAP;
            cause_nxt = 2'b10;
         end else begin
            pc_nxt      = target;
            instret_nxt = instret + 32'd1;
            state_nxt   = fetch_tgt;
         end
      end

      if ((state_nxt != state) && ((state_nxt == S_FETCH) || (state_nxt == S_MEM)))
         cnt_nxt = '0;
   end

   // State, datapath registers and registered handshake/enable outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         ir         <= NOP;
         instret    <= '0;
         trap_cause <= 2'b00;
         cnt        <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 4'b0000;
         rf_we      <= 4'b0000;
         halted     <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         ir         <= ir_nxt;
         instret    <= instret_nxt;
         trap_cause <= cause_nxt;
         cnt        <= cnt_nxt;
         imem_req   <= (state_nxt == S_FETCH);
         dmem_req   <= (state_nxt == S_MEM);
         dmem_we    <= (state_nxt == S_MEM) ? dec_we : 4'b0000;
         rf_we      <= ((state_nxt == S_WB) && (ir_nxt[11:7] != 5'd0)) ? dec_regwrite : 4'b0000;
         halted     <= (state_nxt == S_TRAP);
      end
   end

endmodule

// File: tb/tb_rv32_seq_ctrl.sv
// Directed self-checking bench for rv32_seq_ctrl; the bench plays imem, dmem and decoder.
module tb_rv32_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ready, dmem_req, dmem_ready, halted;
   logic        dec_branch, dec_memread, branch_taken;
   logic [31:0] imem_addr, imem_rdata, ir, pc, imm, alu_result, instret;
   logic [3:0]  dec_we, dec_regwrite, dmem_we, rf_we;
   logic [1:0]  trap_cause;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rv32_seq_ctrl #(.RESET_PC(32'h0000_0100), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .ir(ir), .pc(pc),
      .dec_branch(dec_branch), .dec_memread(dec_memread), .dec_we(dec_we), .dec_regwrite(dec_regwrite),
      .branch_taken(branch_taken), .imm(imm), .alu_result(alu_result),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .rf_we(rf_we), .instret(instret), .halted(halted), .trap_cause(trap_cause)
   );

   task automatic clk1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input logic br, input logic mr, input logic [3:0] we, input logic [3:0] rw,
                          input logic tk, input logic [31:0] im, input logic [31:0] alu);
      dec_branch = br; dec_memread = mr; dec_we = we; dec_regwrite = rw;
      branch_taken = tk; imm = im; alu_result = alu;
   endtask

   task automatic apply_reset;
      rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
      set_dec(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 32'h0);
      clk1; clk1;
      rst = 1'b0;
   endtask

   // Serves one fetch with ready after 'delay' request cycles; returns request cycles seen.
   task automatic do_fetch(input logic [31:0] instr, input int delay, output int n);
      int guard;
      guard = 0; n = 0;
      while (!imem_req && guard < 20) begin clk1; guard++; end
      imem_rdata = instr;
      while (imem_req && n < 50) begin
         n++;
         imem_ready = (n > delay);
         clk1;
      end
      imem_ready = 1'b0;
   endtask

   // Runs from DECODE until the next fetch or a trap, recording rf/dmem activity.
   task automatic finish_instr(input int ddelay, input logic [3:0] exp_we, output int rf_n,
                               output logic [3:0] rf_val, output int dm_n, output int we_bad);
      int guard;
      guard = 0; rf_n = 0; rf_val = 4'h0; dm_n = 0; we_bad = 0;
      while (!imem_req && !halted && guard < 40) begin
         if (rf_we != 4'h0) begin rf_n++; rf_val = rf_we; end
         if (dmem_req) begin
            dm_n++;
            if (dmem_we !== exp_we) we_bad++;
            dmem_ready = (dm_n > ddelay);
         end else begin
            if (dmem_we != 4'h0) we_bad++;
            dmem_ready = 1'b0;
         end
         clk1; guard++;
      end
      dmem_ready = 1'b0;
   endtask

   task automatic test_reset;
      apply_reset;
      tests++; if (pc !== 32'h100) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100); end
      tests++; if (ir !== 32'h13) begin fails++; $display("FAIL reset_ir got %h exp %h", ir, 32'h13); end
      tests++; if (instret !== 32'h0) begin fails++; $display("FAIL reset_instret got %h exp 0", instret); end
      tests++; if ({halted, trap_cause} !== 3'b000) begin fails++; $display("FAIL reset_trap got %b%b exp 000", halted, trap_cause); end
      tests++; if ({imem_req, dmem_req, dmem_we, rf_we} !== 10'h0) begin fails++;
         $display("FAIL reset_outs got %b %b %b %b exp 0", imem_req, dmem_req, dmem_we, rf_we); end
   endtask

   task automatic test_fetch_wb;
      int n, rfn, dmn, web; logic [3:0] rfv;
      do_fetch(32'h0050_0093, 2, n);
      tests++; if (n !== 3) begin fails++; $display("FAIL fetch_req_cycles got %0d exp 3", n); end
      tests++; if (ir !== 32'h0050_0093) begin fails++; $display("FAIL fetch_ir got %h exp 00500093", ir); end
      set_dec(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 32'd5, 32'd5);
      finish_instr(0, 4'h0, rfn, rfv, dmn, web);
      tests++; if (rfn !== 1 || rfv !== 4'hF) begin fails++; $display("FAIL addi_rf_we got %0d cycles %b exp 1 cycle 1111", rfn, rfv); end
      tests++; if (pc !== 32'h104 || imem_addr !== 32'h104) begin fails++; $display("FAIL addi_pc got %h/%h exp 104", pc, imem_addr); end
      tests++; if (instret !== 32'd1) begin fails++; $display("FAIL addi_instret got %0d exp 1", instret); end
   endtask

   task automatic test_store;
      int n, rfn, dmn, web; logic [3:0] rfv;
      do_fetch(32'h0020_A423, 0, n);
      set_dec(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 32'd8, 32'h10D);
      finish_instr(3, 4'hF, rfn, rfv, dmn, web);
      tests++; if (dmn !== 4) begin fails++; $display("FAIL sw_dmem_cycles got %0d exp 4", dmn); end
      tests++; if (web !== 0) begin fails++; $display("FAIL sw_dmem_we_bad got %0d exp 0", web); end
      tests++; if (rfn !== 0) begin fails++; $display("FAIL sw_rf_we got %0d exp 0", rfn); end
      tests++; if (pc !== 32'h108 || instret !== 32'd2) begin fails++; $display("FAIL sw_pc got %h/%0d exp 108/2", pc, instret); end
   endtask

   task automatic test_branch;
      int n, rfn, dmn, web; logic [3:0] rfv;
      do_fetch(32'h0000_00EF, 1, n);
      set_dec(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 32'h0000_00F8, 32'h0);
      finish_instr(0, 4'h0, rfn, rfv, dmn, web);
      tests++; if (pc !== 32'h200) begin fails++; $display("FAIL jal_pc got %h exp 200", pc); end
      do_fetch(32'h0000_0063, 0, n);
      set_dec(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 32'hFFFF_FFF8, 32'h0);
      finish_instr(0, 4'h0, rfn, rfv, dmn, web);
      tests++; if (pc !== 32'h1F8 || instret !== 32'd4) begin fails++; $display("FAIL beq_taken got %h/%0d exp 1f8/4", pc, instret); end
      do_fetch(32'h0000_0063, 0, n);
      set_dec(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 32'h0000_0008, 32'h0);
      finish_instr(0, 4'h0, rfn, rfv, dmn, web);
      do_fetch(32'h0000_0063, 0, n);
      set_dec(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 32'hFFFF_FFF8, 32'h0);
      finish_instr(0, 4'h0, rfn, rfv, dmn, web);
      tests++; if (pc !== 32'h204 || instret !== 32'd6) begin fails++; $display("FAIL beq_not_taken got %h/%0d exp 204/6", pc, instret); end
   endtask

   task automatic test_misaligned;
      int n, rfn, dmn, web; logic [3:0] rfv;
      do_fetch(32'h0000_00E7, 0, n);
      set_dec(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 32'h0, 32'h0000_0302);
      finish_instr(0, 4'h0, rfn, rfv, dmn, web);
      tests++; if (halted !== 1'b1 || trap_cause !== 2'b10) begin fails++; $display("FAIL jalr_trap got %b/%b exp 1/10", halted, trap_cause); end
      clk1; clk1; clk1;
      tests++; if (pc !== 32'h204 || instret !== 32'd6) begin fails++; $display("FAIL jalr_frozen got %h/%0d exp 204/6", pc, instret); end
      tests++; if ({imem_req, dmem_req, rf_we, halted} !== 7'b0000001) begin fails++;
         $display("FAIL trap_outs got %b %b %b %b exp 0 0 0000 1", imem_req, dmem_req, rf_we, halted); end
   endtask

   task automatic test_illegal_timeout;
      int n, rfn, dmn, web; logic [3:0] rfv;
      apply_reset;
      do_fetch(32'h0000_0000, 0, n);
      finish_instr(0, 4'h0, rfn, rfv, dmn, web);
      tests++; if (halted !== 1'b1 || trap_cause !== 2'b01 || instret !== 32'd0) begin fails++;
         $display("FAIL illegal_trap got %b/%b/%0d exp 1/01/0", halted, trap_cause, instret); end
      apply_reset;
      do_fetch(32'h0050_0093, 100, n);
      tests++; if (n !== 4) begin fails++; $display("FAIL timeout_req_cycles got %0d exp 4", n); end
      tests++; if (halted !== 1'b1 || trap_cause !== 2'b11 || pc !== 32'h100) begin fails++;
         $display("FAIL timeout_trap got %b/%b/%h exp 1/11/100", halted, trap_cause, pc); end
   endtask

   task automatic test_reset_mid_mem;
      int n, rfn, dmn, web, guard; logic [3:0] rfv;
      apply_reset;
      do_fetch(32'h0000_0013, 0, n);
      set_dec(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 32'h0, 32'h0);
      finish_instr(0, 4'h0, rfn, rfv, dmn, web);
      tests++; if (rfn !== 0 || pc !== 32'h104 || instret !== 32'd1) begin fails++;
         $display("FAIL addi_x0 got rf %0d pc %h ret %0d exp 0/104/1", rfn, pc, instret); end
      do_fetch(32'h0020_A423, 0, n);
      set_dec(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 32'd8, 32'h10D);
      guard = 0;
      while (!dmem_req && guard < 10) begin clk1; guard++; end
      tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL mem_entry got %b exp 1", dmem_req); end
      clk1; clk1;
      rst = 1'b1;
      clk1;
      tests++; if (dmem_req !== 1'b0 || dmem_we !== 4'h0) begin fails++; $display("FAIL rst_mem_req got %b/%b exp 0/0000", dmem_req, dmem_we); end
      tests++; if (pc !== 32'h100 || instret !== 32'd0) begin fails++; $display("FAIL rst_mem_pc got %h/%0d exp 100/0", pc, instret); end
      rst = 1'b0;
      set_dec(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 32'h0);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_idle got %b exp 0", imem_req); end
      clk1;
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL idle_to_fetch got %b exp 1", imem_req); end
   endtask

   initial begin
      test_reset;
      test_fetch_wb;
      test_store;
      test_branch;
      test_misaligned;
      test_illegal_timeout;
      test_reset_mid_mem;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
